// File: rtl/buff_uart_host.sv
// rtl/buff_uart_host.sv - polling bus host between tx/rx holding registers and a UART peripheral
// Optional transfer counters: define BUFF_UART_HOST_STATS_EN.
module buff_uart_host #(
    parameter int width          = 8,
    parameter int address_width  = 4,
    parameter int rx_address     = 0,
    parameter int tx_address     = 1,
    parameter int status_address = 2,
    parameter int poll_gap       = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     tx_valid,
    input  logic [width-1:0]         tx_data,
    output logic                     tx_ready,
    output logic                     rx_valid,
    output logic [width-1:0]         rx_data,
    input  logic                     rx_ready,
    output logic [address_width-1:0] active_address,
    output logic                     write_enable,
    output logic                     read_enable,
    output logic [width-1:0]         data_out,
    input  logic [width-1:0]         data_in
`ifdef BUFF_UART_HOST_STATS_EN
    ,
    output logic [15:0]              tx_count,
    output logic [15:0]              rx_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        POLL_WAIT,
        FETCH,
        FETCH_WAIT,
        PUSH
    } state_t;

    localparam logic [8:0] GAP = 9'(poll_gap);

    state_t                     state_q, state_d;
    logic [7:0]                 gap_cnt_q, gap_cnt_d;
    logic                       rr_q, rr_d;
    logic                       rx_empty_q, rx_empty_d;
    logic                       tx_full_q, tx_full_d;
    logic                       hold_full_q, hold_full_d;
    logic [width-1:0]           hold_data_q, hold_data_d;
    logic                       rx_valid_q, rx_valid_d;
    logic [width-1:0]           rx_data_q, rx_data_d;
    logic [address_width-1:0]   addr_q, addr_d;
    logic                       we_q, we_d;
    logic                       re_q, re_d;
    logic [width-1:0]           dout_q, dout_d;
    logic                       last_idle;
    logic                       rx_possible;
    logic                       tx_possible;
    logic                       pick_rx;
    logic                       do_fetch;
    logic                       do_push;
`ifdef BUFF_UART_HOST_STATS_EN
    logic [15:0]                tx_cnt_q, tx_cnt_d;
    logic [15:0]                rx_cnt_q, rx_cnt_d;
`endif

    // A gap of zero still spends one cycle in IDLE before polling.
    assign last_idle = ({1'b0, gap_cnt_q} + 9'd1) >= GAP;

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        rr_d        = rr_q;
        rx_empty_d  = rx_empty_q;
        tx_full_d   = tx_full_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        addr_d      = '0;
        we_d        = 1'b0;
        re_d        = 1'b0;
        dout_d      = '0;
        rx_possible = 1'b0;
        tx_possible = 1'b0;
        pick_rx     = 1'b0;
        do_fetch    = 1'b0;
        do_push     = 1'b0;
`ifdef BUFF_UART_HOST_STATS_EN
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
`endif

        if (tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (last_idle) begin
                    gap_cnt_d = '0;
                    state_d   = POLL;
                    addr_d    = address_width'(status_address);
                    we_d      = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            POLL: begin
                state_d = POLL_WAIT;
            end
            POLL_WAIT: begin
                rx_empty_d  = data_in[1];
                tx_full_d   = data_in[0];
                rx_possible = !rx_empty_d && !rx_valid_q;
                tx_possible = !tx_full_d && hold_full_q;
                // Round-robin pointer moves only on ties so the first tie always fetches.
                if (rx_possible && tx_possible) begin
                    pick_rx = !rr_q;
                    rr_d    = !rr_q;
                end else begin
                    pick_rx = rx_possible;
                end
                do_fetch = (rx_possible || tx_possible) && pick_rx;
                do_push  = (rx_possible || tx_possible) && !pick_rx;
                if (do_fetch) begin
                    state_d = FETCH;
                    addr_d  = address_width'(rx_address);
                    we_d    = 1'b1;
                end else if (do_push) begin
                    state_d = PUSH;
                    addr_d  = address_width'(tx_address);
                    re_d    = 1'b1;
                    dout_d  = hold_data_q;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                rx_data_d  = data_in;
                rx_valid_d = 1'b1;
                state_d    = IDLE;
`ifdef BUFF_UART_HOST_STATS_EN
                rx_cnt_d   = rx_cnt_q + 16'd1;
`endif
            end
            PUSH: begin
                hold_full_d = 1'b0;
                state_d     = IDLE;
`ifdef BUFF_UART_HOST_STATS_EN
                tx_cnt_d    = tx_cnt_q + 16'd1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            rr_q        <= 1'b0;
            rx_empty_q  <= 1'b0;
            tx_full_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            dout_q      <= '0;
`ifdef BUFF_UART_HOST_STATS_EN
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            rr_q        <= rr_d;
            rx_empty_q  <= rx_empty_d;
            tx_full_q   <= tx_full_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            re_q        <= re_d;
            dout_q      <= dout_d;
`ifdef BUFF_UART_HOST_STATS_EN
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
`endif
        end
    end

    assign tx_ready       = !hold_full_q;
    assign rx_valid       = rx_valid_q;
    assign rx_data        = rx_data_q;
    assign active_address = addr_q;
    assign write_enable   = we_q;
    assign read_enable    = re_q;
    assign data_out       = dout_q;
`ifdef BUFF_UART_HOST_STATS_EN
    assign tx_count       = tx_cnt_q;
    assign rx_count       = rx_cnt_q;
`endif

endmodule

// File: tb/tb_buff_uart_host.sv
// tb/tb_buff_uart_host.sv - randomized bench for buff_uart_host against a transaction-level model
module tb_buff_uart_host;

    localparam int W      = 8;
    localparam int AW     = 4;
    localparam int GAP    = 4;
    localparam int G      = (GAP == 0) ? 1 : GAP;
    localparam int RXA    = 0;
    localparam int TXA    = 1;
    localparam int STATA  = 2;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          tx_valid = 1'b0;
    logic [W-1:0]  tx_data = '0;
    logic          tx_ready;
    logic          rx_valid;
    logic [W-1:0]  rx_data;
    logic          rx_ready = 1'b0;
    logic [AW-1:0] active_address;
    logic          write_enable;
    logic          read_enable;
    logic [W-1:0]  data_out;
    logic [W-1:0]  data_in = '0;
`ifdef BUFF_UART_HOST_STATS_EN
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;
`endif

    buff_uart_host #(
        .width(W), .address_width(AW), .rx_address(RXA), .tx_address(TXA),
        .status_address(STATA), .poll_gap(GAP)
    ) dut (
        .clock(clock), .resetn(resetn),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .active_address(active_address), .write_enable(write_enable),
        .read_enable(read_enable), .data_out(data_out), .data_in(data_in)
`ifdef BUFF_UART_HOST_STATS_EN
        , .tx_count(tx_count), .rx_count(rx_count)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Stimulus knobs
    int st_mode = -1;
    int tx_pct = 0;
    int rx_pct = 0;
    int tx_fixed = -1;
    int rx_fixed = -1;
    bit reset_on_push = 0;
    bit got_push_reset = 0;

    // Reference model: holding registers, arbitration pointer and the next expected bus event
    bit           m_hold, m_rx_full, m_rr;
    logic [W-1:0] m_hold_word, m_rx_word, fetch_word;
    logic [15:0]  m_tx_cnt, m_rx_cnt;
    logic [1:0]   cur_status;
    int cyc = 0, exp_at = -1, exp_what = 0, decide_at = -1, fetch_cap_at = -1;

    // Observations
    int n_push = 0, n_fetch = 0, poll_last = 0, poll_prev = 0;
    logic [W-1:0] last_push = '0;
    int kinds[$];

    task automatic check_quiet(input string pfx);
        check({pfx, "_we"}, write_enable, 0);
        check({pfx, "_re"}, read_enable, 0);
        check({pfx, "_addr"}, active_address, 0);
        check({pfx, "_tx_ready"}, tx_ready, 1);
        check({pfx, "_rx_valid"}, rx_valid, 0);
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (2) begin
            @(negedge clock);
            cyc++;
        end
        check_quiet("rst");
        check("rst_rx_data", rx_data, 0);
        check("rst_data_out", data_out, 0);
        m_hold = 0; m_rx_full = 0; m_rr = 0;
        m_tx_cnt = '0; m_rx_cnt = '0;
        decide_at = -1; fetch_cap_at = -1;
        exp_at = cyc + G; exp_what = 1;
        resetn = 1'b1;
    endtask

    task automatic step();
        int obs, expk;
        bit rx_p, tx_p, pick_rx;
        logic [W-1:0] tmp;
        @(negedge clock);
        cyc++;
        if (write_enable && read_enable) obs = 9;
        else if (write_enable && active_address == AW'(STATA)) obs = 1;
        else if (write_enable && active_address == AW'(RXA)) obs = 2;
        else if (read_enable && active_address == AW'(TXA)) obs = 3;
        else if (!write_enable && !read_enable && active_address == '0) obs = 0;
        else obs = 9;
        expk = (cyc == exp_at) ? exp_what : 0;
        check("strobe", obs, expk);
        check("tx_ready", tx_ready, !m_hold);
        check("rx_valid", rx_valid, m_rx_full);
        if (m_rx_full) check("rx_data", rx_data, m_rx_word);
        if (obs == 3) check("data_out", data_out, m_hold_word);
`ifdef BUFF_UART_HOST_STATS_EN
        check("tx_count", tx_count, m_tx_cnt);
        check("rx_count", rx_count, m_rx_cnt);
`endif
        if (obs == 1) begin poll_prev = poll_last; poll_last = cyc; end
        if (obs == 2) begin n_fetch++; kinds.push_back(2); end
        if (obs == 3) begin n_push++; kinds.push_back(3); last_push = data_out; end

        if (expk == 3 && reset_on_push) begin
            resetn = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
            got_push_reset = 1;
            return;
        end

        // Peripheral response, valid from the cycle after each strobe
        if (expk == 1) begin
            cur_status = (st_mode < 0) ? 2'($urandom) : 2'(st_mode);
            tmp = W'($urandom);
            tmp[1:0] = cur_status;
            data_in = tmp;
            decide_at = cyc + 1;
        end else if (expk == 2) begin
            fetch_word = (rx_fixed >= 0) ? W'(rx_fixed) : W'($urandom);
            data_in = fetch_word;
            fetch_cap_at = cyc + 1;
        end

        if (cyc == decide_at) begin
            rx_p = !cur_status[1] && !m_rx_full;
            tx_p = !cur_status[0] && m_hold;
            if (rx_p && tx_p) begin pick_rx = !m_rr; m_rr = !m_rr; end
            else pick_rx = rx_p;
            if (rx_p || tx_p) begin exp_at = cyc + 1; exp_what = pick_rx ? 2 : 3; end
            else begin exp_at = cyc + 1 + G; exp_what = 1; end
        end
        if (expk == 2) begin exp_at = cyc + 2 + G; exp_what = 1; end
        if (expk == 3) begin exp_at = cyc + 1 + G; exp_what = 1; end

        tx_valid = (int'($urandom_range(0, 99)) < tx_pct);
        tx_data  = (tx_fixed >= 0) ? W'(tx_fixed) : W'($urandom);
        rx_ready = (int'($urandom_range(0, 99)) < rx_pct);

        if (m_rx_full && rx_ready) m_rx_full = 0;
        if (cyc == fetch_cap_at) begin
            m_rx_full = 1; m_rx_word = fetch_word; m_rx_cnt++;
        end
        if (expk == 3) begin
            m_hold = 0; m_tx_cnt++;
        end else if (tx_valid && !m_hold) begin
            m_hold = 1; m_hold_word = tx_data;
        end
    endtask

    task automatic clear_obs();
        n_push = 0; n_fetch = 0;
        kinds.delete();
    endtask

    initial begin
        do_reset();

        // Single tx word with status rx_empty=1, tx_full=0
        clear_obs();
        st_mode = 2; tx_fixed = 8'h5A; tx_pct = 100;
        step();
        tx_pct = 0;
        repeat (20) step();
        check("req040_pushes", n_push, 1);
        check("req040_word", last_push, 8'h5A);
        check("req040_tx_ready", tx_ready, 1);

        // Fetch with the user not consuming
        clear_obs();
        st_mode = 1; rx_fixed = 8'hC3; rx_pct = 0;
        repeat (30) step();
        check("req041_fetches", n_fetch, 1);
        check("req041_rx_valid", rx_valid, 1);
        check("req041_rx_data", rx_data, 8'hC3);

        // Both blocked: polls only, at a fixed interval
        st_mode = 3; tx_fixed = 8'h11; tx_pct = 100; rx_pct = 100;
        repeat (20) step();
        clear_obs();
        repeat (14) step();
        check("req043_pushes", n_push, 0);
        check("req043_fetches", n_fetch, 0);
        check("req043_interval", poll_last - poll_prev, GAP + 2);

        // First tie after reset fetches, then the pending word goes out
        clear_obs();
        st_mode = 0; tx_pct = 0; rx_pct = 0;
        repeat (24) step();
        check("req042_two_xfers", kinds.size() >= 2, 1);
        if (kinds.size() >= 2) begin
            check("req042_first", kinds[0], 2);
            check("req042_second", kinds[1], 3);
        end

        // Reset in the PUSH cycle
        st_mode = 2; tx_fixed = -1; tx_pct = 100; rx_pct = 100;
        reset_on_push = 1; got_push_reset = 0;
        for (int i = 0; i < 60 && !got_push_reset; i++) step();
        check("req044_push_seen", got_push_reset, 1);
        if (got_push_reset) begin
            @(negedge clock);
            cyc++;
            check_quiet("req044");
        end
        reset_on_push = 0;
        do_reset();

        // Randomized traffic
        clear_obs();
        st_mode = -1; rx_fixed = -1; tx_pct = 60; rx_pct = 50;
        repeat (3000) step();
        check("rand_pushes_seen", n_push > 0, 1);
        check("rand_fetches_seen", n_fetch > 0, 1);

        // Three pushes then two fetches from a fresh reset
        tx_pct = 0; rx_pct = 0;
        do_reset();
        clear_obs();
        st_mode = 2;
        for (int k = 0; k < 3; k++) begin
            tx_fixed = 8'h30 + k; tx_pct = 100;
            step();
            tx_pct = 0;
            repeat (12) step();
        end
        st_mode = 1; rx_fixed = -1;
        for (int k = 0; k < 2; k++) begin
            repeat (14) step();
            rx_pct = 100;
            step();
            rx_pct = 0;
        end
        check("req045_pushes", n_push, 3);
        check("req045_fetches", n_fetch, 2);
`ifdef BUFF_UART_HOST_STATS_EN
        check("req045_tx_count", tx_count, 3);
        check("req045_rx_count", rx_count, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/buff_uart_host.md
BUFF_UART_HOST -- requirements
Module: buff_uart_host

Interface
REQ-001 SHALL have parameter width, default 8: data word bits, matching the peripheral's width.
REQ-002 SHALL have parameter address_width, default 4: bus address bits.
REQ-003 SHALL have parameter rx_address, default 0: peripheral rx-fetch register address.
REQ-004 SHALL have parameter tx_address, default 1: peripheral tx-push register address.
REQ-005 SHALL have parameter status_address, default 2: peripheral status register address.
REQ-006 SHALL have parameter poll_gap, default 4: idle cycles between consecutive status polls; range 0..255.
REQ-007 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-009 SHALL have port tx_valid, input, 1: user offers a word to transmit.
REQ-010 SHALL have port tx_data, input, width: word to transmit.
REQ-011 SHALL have port tx_ready, output, 1: tx holding register empty; word accepted when tx_valid && tx_ready.
REQ-012 SHALL have port rx_valid, output, 1: rx holding register full.
REQ-013 SHALL have port rx_data, output, width: received word.
REQ-014 SHALL have port rx_ready, input, 1: user consumes the word when rx_valid && rx_ready.
REQ-015 SHALL have port active_address, output, address_width: bus address.
REQ-016 SHALL have port write_enable, output, 1: peripheral strobe for status read and rx fetch.
REQ-017 SHALL have port read_enable, output, 1: peripheral strobe for tx push.
REQ-018 SHALL have port data_out, output, width: word pushed to the peripheral tx FIFO.
REQ-019 SHALL have port data_in, input, width: peripheral response; status is bit1 = rx_empty, bit0 = tx_full.

Function
REQ-020 SHALL implement the FSM states IDLE, POLL, POLL_WAIT, FETCH, FETCH_WAIT, PUSH, all registered.
REQ-021 In IDLE: count poll_gap cycles, then go to POLL; a poll_gap of 0 goes to POLL on the next cycle.
REQ-022 In POLL: drive active_address=status_address and write_enable=1 for exactly one cycle, then go to POLL_WAIT.
REQ-023 In POLL_WAIT: sample data_in[1:0] into rx_empty_q/tx_full_q at the end of the cycle after the strobe.
REQ-024 Exit from POLL_WAIT: rx_possible = !rx_empty_q && !rx_valid; tx_possible = !tx_full_q && tx holding full.
REQ-025 If only one of rx_possible/tx_possible is true, go to FETCH or PUSH accordingly; if neither, go to IDLE.
REQ-026 If both are true, alternate round-robin; the first tie after reset goes to FETCH.
REQ-027 In FETCH: drive active_address=rx_address and write_enable=1 for one cycle; in FETCH_WAIT, capture data_in into rx_data, set rx_valid, go to IDLE.
REQ-028 In PUSH: drive active_address=tx_address, read_enable=1 and data_out=tx holding word for one cycle; clear tx holding; go to IDLE.
REQ-029 write_enable and read_enable SHALL never be high in the same cycle; both SHALL be 0 outside POLL/FETCH/PUSH.
REQ-030 active_address SHALL be 0 when no strobe is active.
REQ-031 tx_ready SHALL equal !tx holding full; an accepted word appears on the bus no earlier than 3 cycles later (POLL, POLL_WAIT, PUSH).
REQ-032 A tx accept in the same cycle as PUSH clears holding SHALL NOT occur, since tx_ready is 0 during PUSH (no bypass).
REQ-033 rx_valid SHALL stay high and rx_data stable until rx_ready; consuming it in the FETCH_WAIT cycle is impossible because rx_valid was 0.
REQ-034 Peripheral status SHALL be re-polled before every bus transfer; the host never issues two transfers per poll.

Reset
REQ-035 When resetn=0 at a clock edge: state=IDLE; gap counter=0; round-robin pointer selects rx.
REQ-036 Reset values: rx_valid=0, rx_data=0, tx holding empty (tx_ready=1 after reset), write_enable=0, read_enable=0, active_address=0, data_out=0.
REQ-037 Reset mid-transfer SHALL abandon the transfer; a held tx word is discarded.

Configuration
REQ-038 Macro BUFF_UART_HOST_STATS_EN defined SHALL add outputs tx_count and rx_count (16 bits each); each increments on PUSH or on FETCH_WAIT capture, wraps 65535->0, and resets to 0.
REQ-039 Without BUFF_UART_HOST_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-040 Reset, then tx_valid with tx_data=0x5A and status returning 0b10 -> one read_enable pulse with active_address=1 and data_out=0x5A; tx_ready returns to 1.
REQ-041 Status returning 0b01, peripheral data 0xC3 -> write_enable at address 0, rx_valid=1 with rx_data=0xC3; held while rx_ready=0.
REQ-042 Status returning 0b00 with tx pending and rx_valid=0 -> FETCH first, PUSH on the next poll.
REQ-043 Status returning 0b11 with tx pending -> polls repeat every poll_gap+2 cycles and no transfer occurs.
REQ-044 resetn=0 in the PUSH cycle -> the next cycle has no strobes, tx_ready=1 and rx_valid=0.
REQ-045 With STATS_EN: 3 pushes and 2 fetches -> tx_count=3, rx_count=2.
